// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, credit-limited byte fetch from 1-cycle program memory, FWFT instruction buffer
module instr_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {FETCH, KILL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d, rd_addr_q;
    logic              mem_req_q, mem_req_d, rvalid_q;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        data_q [FIFO_DEPTH];
    logic [7:0]        data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_d  [FIFO_DEPTH];
    logic              push, pop, issue;

    // A request is only issued when the buffer is guaranteed a slot for it
    // plus the read already outstanding, so the memory side never stalls.
    always_comb begin
        push       = rvalid_q && state_q == FETCH && !jump_en;
        pop        = count_q != '0 && instr_ready && !jump_en;
        count_d    = jump_en ? '0 : count_q + CW'(push) - CW'(pop);
        wptr_d     = jump_en ? '0 : wptr_q + PW'(push);
        rptr_d     = jump_en ? '0 : rptr_q + PW'(pop);
        issue      = fetch_en && !jump_en && (count_d + CW'(mem_req_q)) < CW'(FIFO_DEPTH);
        mem_req_d  = issue;
        mem_addr_d = issue ? pc_q : mem_addr_q;
        pc_d       = jump_en ? jump_target : pc_q + ADDR_W'(issue);
        state_d    = (jump_en && mem_req_q) ? KILL : FETCH;
        data_d     = data_q;
        tag_d      = tag_q;
        if (push) begin
            data_d[wptr_q] = mem_rdata;
            tag_d[wptr_q]  = rd_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rvalid_q   <= 1'b0;
            rd_addr_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            data_q     <= '{default: '0};
            tag_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rvalid_q   <= mem_req_q;
            rd_addr_q  <= mem_addr_q;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = data_q[rptr_q];
    assign instr_pc    = tag_q[rptr_q];
    assign instr_valid = count_q != '0;
endmodule
